approach_sequencer: RTL

Parametrised successor to the single-pass autoapproach controller. It replays a stored piezo step waveform of programmable length from Block RAM into the DAC, sample by sample, with a programmable inter-sample delay. After each full waveform pass it takes an averaged ADC reading and compares it against a setpoint. It repeats passes until contact is detected, a cycle limit expires, or software disarms it. It sits between the CSR/BRAM waveform store and the shared DAC/ADC SPI masters.

---
 rtl/approach_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/approach_sequencer.sv
// Repeating piezo approach: replays a BRAM waveform into the DAC, then averages
// ADC readings after each pass and stops on contact, pass limit or disarm.
module approach_sequencer #(
  parameter int         DAC_WID      = 24,
  parameter int         DAC_DATA_WID = 20,
  parameter logic [3:0] DAC_CMD      = 4'b0001,
  parameter int         ADC_WID      = 24,
  parameter int         TIMER_WID    = 32,
  parameter int         ADDR_WID     = 10,
  parameter int         CYCLE_WID    = 16,
  parameter int         AVG_LOG2     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    polarity,
  input  logic [ADC_WID-1:0]      setpoint,
  input  logic [TIMER_WID-1:0]    time_to_wait,
  input  logic [ADDR_WID-1:0]     wave_len,
  input  logic [CYCLE_WID-1:0]    max_cycles,
  output logic                    stopped,
  output logic                    detected,
  output logic                    timed_out,
  output logic [CYCLE_WID-1:0]    cycle_count,
  output logic [ADC_WID-1:0]      avg_out,
  output logic [ADDR_WID-1:0]     word_addr,
  input  logic [DAC_DATA_WID-1:0] word,
  output logic                    dac_arm,
  input  logic                    dac_finished,
  output logic [DAC_WID-1:0]      dac_out,
  output logic                    adc_arm,
  input  logic                    adc_finished,
  input  logic [ADC_WID-1:0]      measurement
);

  localparam int ACC_WID = ADC_WID + AVG_LOG2;
  localparam int CNT_WID = AVG_LOG2 + 1;
  localparam logic [CNT_WID-1:0] LAST_SAMPLE = CNT_WID'((1 << AVG_LOG2) - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_FETCH, S_LATCH, S_DAC,
    S_ADC_REQ, S_ADC_GAP, S_CHECK, S_DETECTED, S_TIMEOUT
  } state_t;

  state_t state_reg, state_next;

  logic [TIMER_WID-1:0]      timer_reg, ttw_reg;
  logic [ADDR_WID-1:0]       len_reg, word_addr_reg;
  logic [CYCLE_WID-1:0]      max_reg, cycle_reg;
  logic                      pol_reg;
  logic signed [ADC_WID-1:0] setpoint_reg, avg_reg;
  logic signed [ACC_WID-1:0] acc_reg;
  logic [CNT_WID-1:0]        sample_reg;
  logic [DAC_WID-1:0]        dac_out_reg;

  logic signed [ACC_WID-1:0] meas_ext, acc_sum, acc_shift;
  logic signed [ADC_WID-1:0] avg_calc;
  logic [CYCLE_WID-1:0]      cycle_inc;
  logic                      match, last_word, hit_limit;

  assign meas_ext  = ACC_WID'($signed(measurement));
  assign acc_sum   = acc_reg + meas_ext;
  assign acc_shift = acc_reg >>> AVG_LOG2;
  assign avg_calc  = acc_shift[ADC_WID-1:0];
  assign match     = pol_reg ? (avg_calc >= setpoint_reg) : (avg_calc <= setpoint_reg);
  // Saturation only matters when unlimited; a nonzero limit is hit first.
  assign cycle_inc = (cycle_reg == '1) ? cycle_reg : cycle_reg + CYCLE_WID'(1);
  assign hit_limit = (max_reg != '0) && (cycle_inc == max_reg);
  assign last_word = (word_addr_reg == len_reg - ADDR_WID'(1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (arm && wave_len != '0) state_next = S_WAIT;
      S_WAIT:    if (!arm) state_next = S_IDLE;
                 else if (timer_reg == '0) state_next = S_FETCH;
      S_FETCH:   state_next = arm ? S_LATCH : S_IDLE;
      S_LATCH:   state_next = arm ? S_DAC : S_IDLE;
      S_DAC:     if (dac_finished) begin
                   if (!arm)           state_next = S_IDLE;
                   else if (last_word) state_next = S_ADC_REQ;
                   else                state_next = S_WAIT;
                 end
      S_ADC_REQ: if (adc_finished) begin
                   if (!arm)                          state_next = S_IDLE;
                   else if (sample_reg == LAST_SAMPLE) state_next = S_CHECK;
                   else                               state_next = S_ADC_GAP;
                 end
      S_ADC_GAP: state_next = arm ? S_ADC_REQ : S_IDLE;
      S_CHECK:   if (match)          state_next = S_DETECTED;
                 else if (hit_limit) state_next = S_TIMEOUT;
                 else                state_next = S_WAIT;
      S_DETECTED, S_TIMEOUT: if (!arm) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg     <= '0;
      ttw_reg       <= '0;
      len_reg       <= '0;
      max_reg       <= '0;
      pol_reg       <= 1'b0;
      setpoint_reg  <= '0;
      word_addr_reg <= '0;
      cycle_reg     <= '0;
      acc_reg       <= '0;
      sample_reg    <= '0;
      avg_reg       <= '0;
      dac_out_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (state_next == S_WAIT) begin
          ttw_reg       <= time_to_wait;
          len_reg       <= wave_len;
          max_reg       <= max_cycles;
          pol_reg       <= polarity;
          setpoint_reg  <= setpoint;
          word_addr_reg <= '0;
          cycle_reg     <= '0;
          acc_reg       <= '0;
          sample_reg    <= '0;
        end
        S_WAIT:  if (timer_reg != '0) timer_reg <= timer_reg - TIMER_WID'(1);
        S_LATCH: dac_out_reg <= {DAC_CMD, word};
        S_DAC: if (dac_finished && arm)
          word_addr_reg <= last_word ? '0 : word_addr_reg + ADDR_WID'(1);
        S_ADC_REQ: if (adc_finished && arm) begin
          acc_reg    <= acc_sum;
          sample_reg <= sample_reg + CNT_WID'(1);
        end
        S_CHECK: begin
          avg_reg    <= avg_calc;
          acc_reg    <= '0;
          sample_reg <= '0;
          if (!match) cycle_reg <= cycle_inc;
        end
        default: ;
      endcase
      // Every entry into WAIT starts a fresh inter-sample delay.
      if (state_next == S_WAIT && state_reg != S_WAIT)
        timer_reg <= (state_reg == S_IDLE) ? time_to_wait : ttw_reg;
    end
  end

  always_comb begin
    stopped     = (state_reg == S_IDLE);
    detected    = (state_reg == S_DETECTED);
    timed_out   = (state_reg == S_TIMEOUT);
    dac_arm     = (state_reg == S_DAC);
    adc_arm     = (state_reg == S_ADC_REQ);
    cycle_count = cycle_reg;
    avg_out     = avg_reg;
    word_addr   = word_addr_reg;
    dac_out     = dac_out_reg;
  end

endmodule
